menu_nav_ctrl: RTL and testbench
================================

// Module: menu_nav_ctrl
// PURPOSE
//  Drives the menu block's 4-bit state input from the raw board buttons and produces the matching button events.
//  - Synchronises and debounces btnL/btnR/btnC.
//  - Tracks the highlighted menu item and launches the selected app.
//  - Returns to the menu on a long btnC press while an app runs.
//  - Sits between the top-level pins and the menu block and apps; emits one-cycle button pulses for them.
// PARAMETERS
//  DEBOUNCE_CYCLES    1000000   consecutive stable cycles before a debounced level changes (min 2)
//  LONG_PRESS_CYCLES  100000000 debounced btnC high cycles, while in an app, that force a return to the menu
// PORTS
//  CLK        in   1  system clock; all logic on posedge
//  RESETN     in   1  asynchronous, active-low reset
//  btnL       in   1  raw left button, asynchronous to CLK
//  btnR       in   1  raw right button, asynchronous to CLK
//  btnC       in   1  raw centre button, asynchronous to CLK
//  state      out  4  0=MENU_INACTIVE (app running), 1=MENU_OLED_A, 2=MENU_OLED_B, 3=MENU_AVI (item highlighted)
//  app_id     out  2  app last launched: 0=none, 1..3 = item code
//  pulse_l    out  1  one-cycle pulse on debounced btnL rising edge
//  pulse_r    out  1  one-cycle pulse on debounced btnR rising edge
//  pulse_c    out  1  one-cycle pulse on debounced btnC rising edge
// BEHAVIOUR
//  Reset (async assert, sync release):
//  - state=1, app_id=0, all pulses=0.
//  - Debounced levels=0, all counters=0, long-press arm=0.
//  Input path, per button:
//  - 2-FF synchroniser, then a debounce counter.
//  - Counter increments while the synced sample differs from the debounced level; it clears when they match.
//  - When the counter reaches DEBOUNCE_CYCLES-1 and the sample still differs, the level flips and the counter clears.
//  - Pulse = registered (level & ~level_d1).
//  - Latency, clean raw rising edge to pulse: exactly DEBOUNCE_CYCLES+3 cycles.
//  - Glitch shorter than DEBOUNCE_CYCLES cycles: no level change, no pulse.
//  - Pulses are driven in every state; state updates on the same edge on which a pulse is high.
//  State machine (state 1..3 = MENU, 0 = APP):
//  - MENU, pulse_r only: cursor+1; 3 wraps to 1.
//  - MENU, pulse_l only: cursor-1; 1 wraps to 3.
//  - MENU, pulse_l and pulse_r in the same cycle: no move.
//  - MENU, pulse_c (wins over simultaneous l/r): app_id<=state, state<=0, arm<=0.
//  - APP, pulse_c: arm<=1 and long counter clears. This requires a fresh press, so the launching press can never count as a long press.
//  - APP, armed with btnC debounced high: the long counter increments.
//  - Counter reaches LONG_PRESS_CYCLES-1: state<=app_id (cursor restored), arm<=0, counter clears.
//  - APP, debounced btnC falls before that: arm<=0, counter clears, state unchanged (short press, seen by the app via pulse_c).
//  - pulse_l and pulse_r in APP never change state.
//  - app_id holds through the return to MENU; it changes only on a launch.
//  - The long counter saturates and is LONG_PRESS_CYCLES wide (clog2); no wrap.
//  - Outputs are registered; there are no combinational paths from inputs to outputs.
// TESTING (bench: DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=16)
//  1. Reset, hold btnR high 10 cycles -> pulse_r high once, exactly 7 cycles after the edge; state 1->2.
//  2. From state=1, btnL press -> state=3 (wrap). Then 3 btnR presses -> state goes 1,2,3.
//  3. 2-cycle glitch on btnC -> no pulse_c, state unchanged.
//     btnL and btnR rising on the same cycle -> both pulses high, state unchanged.
//  4. state=2, press btnC and hold 40 cycles -> state=0, app_id=2, no return to menu while held.
//     Release, press again 5 cycles -> state stays 0.
//     Press again 25 cycles -> state=2 on the 16th debounced-high cycle.
//  5. btnC and btnR rising together in state=1 -> state=0, app_id=1, cursor not moved.
//  6. Assert RESETN mid long press (state 0, counter=10) -> state=1, app_id=0 immediately, no pulses after release.

Source files
------------

// File: rtl/menu_nav_ctrl_if.sv
// menu_nav_ctrl_if: raw board buttons in, menu state and button pulses out
interface menu_nav_ctrl_if;
  logic btnL, btnR, btnC;
  logic [3:0] state;
  logic [1:0] app_id;
  logic pulse_l, pulse_r, pulse_c;
  modport master(output btnL, btnR, btnC, input state, app_id, pulse_l, pulse_r, pulse_c);
  modport slave(input btnL, btnR, btnC, output state, app_id, pulse_l, pulse_r, pulse_c);
endinterface

// File: rtl/menu_nav_ctrl.sv
// menu_nav_ctrl: debounces the board buttons and navigates between menu items and the launched app
module menu_nav_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_PRESS_CYCLES = 100000000
) (
  input logic CLK,
  input logic RESETN,
  menu_nav_ctrl_if.slave nav
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int LW = $clog2(LONG_PRESS_CYCLES);
  typedef enum logic [3:0] {APP = 4'd0, OLED_A = 4'd1, OLED_B = 4'd2, AVI = 4'd3} navState_t;
  logic rstMeta, rstN;
  logic [2:0] raw, sync1, sync2, lvl, lvlD, pulse;
  logic [2:0][DW-1:0] dbCnt;
  navState_t st, stNext;
  logic [1:0] app, appNext;
  logic arm, armNext;
  logic [LW-1:0] lc, lcNext;
  assign raw = {nav.btnL, nav.btnR, nav.btnC};
  // reset asserts immediately but is released on a clock edge
  always_ff @(posedge CLK or negedge RESETN)
    if (!RESETN) {rstN, rstMeta} <= 2'b00;
    else {rstN, rstMeta} <= {rstMeta, 1'b1};
  always_ff @(posedge CLK or negedge rstN) begin
    if (!rstN) begin
      sync1 <= '0;
      sync2 <= '0;
      lvl <= '0;
      lvlD <= '0;
      pulse <= '0;
      dbCnt <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      lvlD <= lvl;
      pulse <= lvl & ~lvlD;
      for (int i = 0; i < 3; i++)
        if (sync2[i] == lvl[i]) dbCnt[i] <= '0;
        else if (dbCnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          lvl[i] <= sync2[i];
          dbCnt[i] <= '0;
        end else dbCnt[i] <= dbCnt[i] + 1'b1;
    end
  end
  always_ff @(posedge CLK or negedge rstN) begin
    if (!rstN) begin
      st <= OLED_A;
      app <= '0;
      arm <= 1'b0;
      lc <= '0;
    end else begin
      st <= stNext;
      app <= appNext;
      arm <= armNext;
      lc <= lcNext;
    end
  end
  // pulse bits: [2]=left, [1]=right, [0]=centre
  always_comb begin
    stNext = st;
    appNext = app;
    armNext = arm;
    lcNext = lc;
    if (st != APP) begin
      if (pulse[0]) begin
        appNext = st[1:0];
        stNext = APP;
        armNext = 1'b0;
      end else if (pulse[2] && !pulse[1]) stNext = st == OLED_A ? AVI : navState_t'(st - 4'd1);
      else if (pulse[1] && !pulse[2]) stNext = st == AVI ? OLED_A : navState_t'(st + 4'd1);
    end else if (pulse[0]) begin
      armNext = 1'b1;
      lcNext = '0;
    end else if (arm && lvl[0]) begin
      if (lc == LW'(LONG_PRESS_CYCLES - 1)) begin
        stNext = navState_t'({2'b00, app});
        armNext = 1'b0;
        lcNext = '0;
      end else lcNext = lc + 1'b1;
    end else if (arm) begin
      armNext = 1'b0;
      lcNext = '0;
    end
  end
  assign nav.state = st;
  assign nav.app_id = app;
  assign {nav.pulse_l, nav.pulse_r, nav.pulse_c} = pulse;
endmodule

// File: tb/tb_menu_nav_ctrl.sv
// tb_menu_nav_ctrl: scoreboard bench for menu_nav_ctrl with short debounce/long-press timings
module tb_menu_nav_ctrl;
  typedef struct {logic [2:0] p; logic [3:0] st; logic [1:0] app;} exp_t;
  logic CLK = 0, RESETN = 0;
  menu_nav_ctrl_if ifc();
  menu_nav_ctrl #(.DEBOUNCE_CYCLES(4), .LONG_PRESS_CYCLES(16)) dut(.CLK(CLK), .RESETN(RESETN), .nav(ifc));
  always #5 CLK = ~CLK;
  int total = 0, bad = 0;
  exp_t sb[$];
  logic [3:0] mState = 4'd1;
  logic [1:0] mApp = 2'd0;
  exp_t pendE;
  logic pend = 0;
  task automatic check(input string tag, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask
  // every pulse must match the oldest expected press; the resulting state is checked a cycle later
  always @(negedge CLK) begin
    if (pend) begin
      check("post_state", ifc.state, pendE.st);
      check("post_app", ifc.app_id, pendE.app);
      pend = 0;
    end
    if (RESETN && (ifc.pulse_l || ifc.pulse_r || ifc.pulse_c)) begin
      if (sb.size() == 0) check("unexp_pulse", {ifc.pulse_l, ifc.pulse_r, ifc.pulse_c}, 0);
      else begin
        pendE = sb.pop_front();
        check("pulse", {ifc.pulse_l, ifc.pulse_r, ifc.pulse_c}, pendE.p);
        pend = 1;
      end
    end
  end
  task automatic press(input logic [2:0] b, input int n);
    if (mState != 0) begin
      if (b[0]) begin
        mApp = mState[1:0];
        mState = 4'd0;
      end else if (b[2] && !b[1]) mState = mState == 4'd1 ? 4'd3 : mState - 4'd1;
      else if (b[1] && !b[2]) mState = mState == 4'd3 ? 4'd1 : mState + 4'd1;
    end
    sb.push_back('{p: b, st: mState, app: mApp});
    @(posedge CLK); #1 {ifc.btnL, ifc.btnR, ifc.btnC} = b;
    repeat (n) @(posedge CLK);
    #1 {ifc.btnL, ifc.btnR, ifc.btnC} = 3'b000;
    repeat (12) @(posedge CLK);
    @(negedge CLK);
    check("settle_state", ifc.state, mState);
    check("settle_app", ifc.app_id, mApp);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
  initial begin
    int n, hit;
    logic got;
    {ifc.btnL, ifc.btnR, ifc.btnC} = 3'b000;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_state", ifc.state, 1);
    check("rst_app", ifc.app_id, 0);
    check("rst_pulses", {ifc.pulse_l, ifc.pulse_r, ifc.pulse_c}, 0);
    @(posedge CLK); #1 RESETN = 1;
    repeat (4) @(posedge CLK);
    mState = 4'd2;
    sb.push_back('{p: 3'b010, st: 4'd2, app: 2'd0});
    @(posedge CLK); #1 ifc.btnR = 1;
    n = 0;
    got = 0;
    while (n < 12 && !got) begin
      @(posedge CLK);
      n++;
      @(negedge CLK);
      got = ifc.pulse_r;
    end
    check("latency_r", n, 7);
    repeat (n < 10 ? 10 - n : 0) @(posedge CLK);
    #1 ifc.btnR = 0;
    repeat (12) @(posedge CLK);
    @(negedge CLK);
    check("t1_state", ifc.state, 2);
    press(3'b100, 6);
    press(3'b100, 6);
    press(3'b010, 6);
    press(3'b010, 6);
    press(3'b010, 6);
    @(posedge CLK); #1 ifc.btnC = 1;
    repeat (2) @(posedge CLK);
    #1 ifc.btnC = 0;
    repeat (12) @(posedge CLK);
    @(negedge CLK);
    check("glitch_state", ifc.state, 3);
    press(3'b110, 6);
    press(3'b100, 6);
    press(3'b001, 40);
    press(3'b001, 5);
    sb.push_back('{p: 3'b001, st: 4'd0, app: mApp});
    @(posedge CLK); #1 ifc.btnC = 1;
    hit = 0;
    for (int i = 1; i <= 25; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (i == 12) check("long_early", ifc.state, 0);
      if (hit == 0 && ifc.state == 4'd2) hit = i;
    end
    check("long_return", hit >= 20 && hit <= 25, 1);
    @(posedge CLK); #1 ifc.btnC = 0;
    mState = 4'd2;
    repeat (12) @(posedge CLK);
    @(negedge CLK);
    check("long_after_state", ifc.state, 2);
    check("long_after_app", ifc.app_id, 2);
    press(3'b100, 6);
    press(3'b011, 6);
    sb.push_back('{p: 3'b001, st: 4'd0, app: mApp});
    @(posedge CLK); #1 ifc.btnC = 1;
    repeat (18) @(posedge CLK);
    #1 RESETN = 0;
    ifc.btnC = 0;
    mState = 4'd1;
    mApp = 2'd0;
    #1 check("rst_async_state", ifc.state, 1);
    check("rst_async_app", ifc.app_id, 0);
    repeat (3) @(posedge CLK);
    #1 RESETN = 1;
    repeat (20) @(posedge CLK);
    @(negedge CLK);
    check("rst_after_state", ifc.state, 1);
    check("rst_after_app", ifc.app_id, 0);
    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
